// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control bit map and bubble constant for the pipeline registers
package pipe_pkg;
  localparam int ADDR_W = 5;
  localparam int WORD = 32;
  localparam int CTRL_W = 9;
  localparam int REGWRITE = 0;
  localparam int MEMTORE = 1;
  localparam int MEMREAD = 2;
  localparam int MEMWRITE = 3;
  localparam int ALUSRC = 4;
  localparam int REGDST = 5;
  localparam int BRANCH = 6;
  localparam int ALUOP_LO = 7;
  localparam int ALUOP_HI = 8;
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use detector; ports ex_valid/ex_memread/ex_rt (EX load), id_valid/id_rs/id_rt/id_alusrc/id_memwrite/id_branch (ID), hold -> load_use, stall_id
module hazard_detect #(
  parameter int ADDR_W = pipe_pkg::ADDR_W
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_alusrc,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic              hold,
  output logic              load_use,
  output logic              stall_id
);
  logic uses_rt;
  assign uses_rt = ~id_alusrc | id_memwrite | id_branch;
  assign load_use = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
                    ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
  assign stall_id = hold | load_use;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use bubble, hold and flush; ports clk, rst_n, id_* in, hold, flush, ex_* out, stall_id; HAZARD_STATS_EN adds bubble_cnt/flush_cnt
module id_ex_reg #(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int WORD = pipe_pkg::WORD,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [WORD-1:0]   id_pc4,
  input  logic [WORD-1:0]   id_rs_data,
  input  logic [WORD-1:0]   id_rt_data,
  input  logic [WORD-1:0]   id_imm,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [WORD-1:0]   ex_pc4,
  output logic [WORD-1:0]   ex_rs_data,
  output logic [WORD-1:0]   ex_rt_data,
  output logic [WORD-1:0]   ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              stall_id
);
  import pipe_pkg::*;
  localparam int N = 1 + 4*WORD + 3*ADDR_W + CTRL_W;
  logic [N-1:0] cur, nxt;
  logic load_use;
  assign {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl} = cur;
  hazard_detect #(.ADDR_W(ADDR_W)) u_hd (
    .ex_valid(ex_valid), .ex_memread(ex_ctrl[MEMREAD]), .ex_rt(ex_rt),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_alusrc(id_ctrl[ALUSRC]), .id_memwrite(id_ctrl[MEMWRITE]), .id_branch(id_ctrl[BRANCH]),
    .hold(hold), .load_use(load_use), .stall_id(stall_id)
  );
  always_comb nxt = flush ? '0 : hold ? cur : load_use ? '0 :
    {id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
     id_valid ? id_ctrl : CTRL_W'(BUBBLE_CTRL)};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= '0;
    else cur <= nxt;
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      bubble_cnt <= bubble_cnt + 32'(!flush && !hold && load_use);
      flush_cnt <= flush_cnt + 32'(flush);
    end
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed checks of reset, capture, load-use bubble, hold and flush
module tb_id_ex_reg;
  logic clk = 0, rst_n, id_valid, hold, flush, ex_valid, stall_id;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm, ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
  logic [8:0] id_ctrl, ex_ctrl;
`ifdef HAZARD_STATS_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif
  int n_chk = 0, n_pass = 0;
  localparam logic [8:0] LW = 9'h017, ADD = 9'h121, ADDI = 9'h011, SW = 9'h018;
  always #5 clk = ~clk;
  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .hold(hold), .flush(flush), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
`ifdef HAZARD_STATS_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .stall_id(stall_id)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] pc);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_pc4 = pc;
    id_rs_data = pc ^ 32'hA5A5_0000; id_rt_data = ~pc; id_imm = pc << 4;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0; hold = 0; flush = 0;
    drive(1, 9'h1FF, 1, 2, 3, 32'h10);
    tick;
    rst_n = 1;
    tick;
    check("cap_ctrl", 32'(ex_ctrl), 32'h1FF);
    #3 rst_n = 0;
    #1;
    check("rst_ctrl", 32'(ex_ctrl), 0);
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_pc4", ex_pc4, 0);
    check("rst_imm", ex_imm, 0);
    check("rst_stall", 32'(stall_id), 0);
    rst_n = 1;
    tick;
    check("rel_ctrl", 32'(ex_ctrl), 32'h1FF);
    check("rel_valid", 32'(ex_valid), 1);
    check("rel_rt_data", ex_rt_data, ~32'h10);
    check("rel_stall_rt", 32'(stall_id), 1);
    // lw $8 then dependent add through rs
    drive(1, LW, 9, 8, 0, 32'h100);
    check("lw_nostall", 32'(stall_id), 0);
    tick;
    check("lw_rt", 32'(ex_rt), 8);
    drive(1, ADD, 8, 3, 10, 32'h104);
    check("lu_stall", 32'(stall_id), 1);
    tick;
    check("bub_valid", 32'(ex_valid), 0);
    check("bub_ctrl", 32'(ex_ctrl), 0);
    check("bub_pc4", ex_pc4, 0);
    check("bub_stall", 32'(stall_id), 0);
    tick;
    check("add_ctrl", 32'(ex_ctrl), 32'(ADD));
    check("add_pc4", ex_pc4, 32'h104);
    check("add_rs_data", ex_rs_data, 32'hA5A5_0104);
    check("add_rd", 32'(ex_rd), 10);
    // $0 never stalls
    drive(1, LW, 1, 0, 0, 32'h108);
    tick;
    drive(1, ADD, 0, 0, 4, 32'h10C);
    check("zero_stall", 32'(stall_id), 0);
    tick;
    check("zero_cap", 32'(ex_ctrl), 32'(ADD));
    // rt use depends on instruction class
    drive(1, LW, 1, 8, 0, 32'h110);
    tick;
    drive(1, SW, 4, 8, 0, 32'h114);
    check("sw_rt_stall", 32'(stall_id), 1);
    drive(1, ADD, 4, 8, 5, 32'h114);
    check("add_rt_stall", 32'(stall_id), 1);
    drive(0, ADD, 8, 8, 5, 32'h114);
    check("inval_nostall", 32'(stall_id), 0);
    drive(1, ADDI, 4, 8, 0, 32'h114);
    check("addi_nostall", 32'(stall_id), 0);
    tick;
    check("addi_cap", 32'(ex_ctrl), 32'(ADDI));
    // hold freezes, flush beats hold
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, ADD, 5'(i), 5'(i+1), 5'(i+2), 32'h200 + 32'(i));
      check("hold_stall", 32'(stall_id), 1);
      tick;
      check("hold_pc4", ex_pc4, 32'h114);
      check("hold_ctrl", 32'(ex_ctrl), 32'(ADDI));
    end
    flush = 1;
    tick;
    check("hflush_valid", 32'(ex_valid), 0);
    check("hflush_imm", ex_imm, 0);
    hold = 0; flush = 0;
    // flush together with load-use
    drive(1, LW, 1, 8, 0, 32'h300);
    tick;
    drive(1, ADD, 8, 2, 3, 32'h304);
    flush = 1;
    #1;
    check("fl_lu_stall", 32'(stall_id), 1);
    tick;
    check("fl_lu_ctrl", 32'(ex_ctrl), 0);
    check("fl_lu_valid", 32'(ex_valid), 0);
`ifdef HAZARD_STATS_EN
    check("flush_cnt", flush_cnt, 2);
    check("bubble_cnt", bubble_cnt, 1);
`endif
    flush = 0;
    tick;
    check("fl_after", 32'(ex_ctrl), 32'(ADD));
`ifdef HAZARD_STATS_EN
    #2 force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt;
`endif
    // back-to-back load bubbles
    for (int i = 0; i < 2; i++) begin
      drive(1, LW, 1, 5'(8+i), 0, 32'h400);
      tick;
      drive(1, ADD, 5'(8+i), 2, 3, 32'h404);
      check("b2b_stall", 32'(stall_id), 1);
      tick;
      check("b2b_bub", 32'(ex_valid), 0);
      tick;
      check("b2b_cap", 32'(ex_ctrl), 32'(ADD));
    end
`ifdef HAZARD_STATS_EN
    check("bubble_wrap", bubble_cnt, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
